// File: rtl/switch_game_engine.sv
// switch_game_engine: reaction-game core. Owns the round FSM, the prompt
// sequence, the per-second countdown, streak-multiplied scoring and a
// high score that survives until reset. All outputs are plain binary.
module switch_game_engine #(
  parameter int NUM_SW        = 10,
  parameter int TICKS_PER_SEC = 50000000,
  parameter int ROUND_SECONDS = 20,
  parameter int PROMPT_STEP   = 7,
  parameter int STREAK_LEN    = 5,
  parameter int MAX_MULT      = 8,
  parameter int SCORE_W       = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NUM_SW-1:0]  sw,
  output logic [NUM_SW-1:0]  led_prompt,
  output logic [7:0]         seconds_left,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [7:0]         multiplier,
  output logic               playing,
  output logic               game_over,
  output logic               new_high
);

  localparam int IDX_W    = $clog2(NUM_SW);
  localparam int TICK_W   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int STREAK_W = $clog2(STREAK_LEN + 1);
  localparam int STEP_MOD = PROMPT_STEP % NUM_SW;
  localparam int SUM_W    = ((SCORE_W > 9) ? SCORE_W : 9) + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {IDLE, PLAY, GAMEOVER} state_t;

  state_t              state, state_n;
  logic [NUM_SW-1:0]   sw_meta, sw_s, sw_prev;
  logic [NUM_SW-1:0]   expected, expected_n;
  logic [IDX_W-1:0]    idx, idx_n, idx_adv;
  logic [IDX_W:0]      idx_sum;
  logic [TICK_W-1:0]   tick, tick_n;
  logic [7:0]          sec_n, mult_n;
  logic [8:0]          mult_dbl;
  logic [7:0]          mult_up;
  logic [SCORE_W-1:0]  score_n, high_n, score_add;
  logic [SUM_W-1:0]    score_sum;
  logic [STREAK_W-1:0] streak, streak_n;
  logic                new_high_n;
  logic                change;

  function automatic logic [NUM_SW-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_SW-1:0] one;
    one = {{(NUM_SW-1){1'b0}}, 1'b1};
    return one << i;
  endfunction

  // Two-flop synchroniser for the raw switches, plus the previous sample for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_s    <= '0;
      sw_prev <= '0;
    end else begin
      sw_meta <= sw;
      sw_s    <= sw_meta;
      sw_prev <= sw_s;
    end
  end

  assign change = (sw_s != sw_prev);

  // Shared arithmetic: next prompt index, saturating score add, capped multiplier doubling
  always_comb begin
    idx_sum   = {1'b0, idx} + (IDX_W+1)'(STEP_MOD);
    idx_adv   = (idx_sum >= (IDX_W+1)'(NUM_SW)) ? IDX_W'(idx_sum - (IDX_W+1)'(NUM_SW))
                                                : IDX_W'(idx_sum);
    score_sum = SUM_W'(score) + SUM_W'({multiplier, 1'b0});
    score_add = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(score_sum);
    mult_dbl  = {multiplier, 1'b0};
    mult_up   = (mult_dbl > 9'(MAX_MULT)) ? 8'(MAX_MULT) : mult_dbl[7:0];
  end

  // Round FSM: start handling, answer scoring, countdown and high-score capture
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    expected_n = expected;
    tick_n     = tick;
    sec_n      = seconds_left;
    score_n    = score;
    high_n     = high_score;
    mult_n     = multiplier;
    streak_n   = streak;
    new_high_n = 1'b0;
    case (state)
      IDLE, GAMEOVER: begin
        if (start) begin
          state_n    = PLAY;
          score_n    = '0;
          streak_n   = '0;
          mult_n     = 8'd1;
          sec_n      = 8'(ROUND_SECONDS);
          tick_n     = '0;
          expected_n = sw_s ^ onehot(idx);
        end
      end
      PLAY: begin
        if (change) begin
          if (sw_s == expected) begin
            score_n = score_add;
            if (streak == STREAK_W'(STREAK_LEN - 1)) begin
              streak_n = '0;
              mult_n   = mult_up;
            end else begin
              streak_n = streak + 1'b1;
            end
          end else begin
            streak_n = '0;
            mult_n   = 8'd1;
          end
          idx_n      = idx_adv;
          expected_n = sw_s ^ onehot(idx_adv);
        end
        if (tick == TICK_W'(TICKS_PER_SEC - 1)) begin
          tick_n = '0;
          sec_n  = seconds_left - 8'd1;
          if (seconds_left == 8'd1) begin
            state_n = GAMEOVER;
            if (score_n > high_score) begin
              high_n     = score_n;
              new_high_n = 1'b1;
            end
          end
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      expected     <= '0;
      tick         <= '0;
      seconds_left <= 8'(ROUND_SECONDS);
      score        <= '0;
      high_score   <= '0;
      multiplier   <= 8'd1;
      streak       <= '0;
      new_high     <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      expected     <= expected_n;
      tick         <= tick_n;
      seconds_left <= sec_n;
      score        <= score_n;
      high_score   <= high_n;
      multiplier   <= mult_n;
      streak       <= streak_n;
      new_high     <= new_high_n;
    end
  end

  // Status outputs decoded from the current state
  always_comb begin
    led_prompt = '0;
    playing    = 1'b0;
    game_over  = 1'b0;
    case (state)
      PLAY: begin
        led_prompt = onehot(idx);
        playing    = 1'b1;
      end
      GAMEOVER: begin
        led_prompt = '1;
        game_over  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_switch_game_engine.sv
// tb_switch_game_engine: directed bench with a score/multiplier/prompt scoreboard.
// A fast instance (4 ticks/s) covers timing, high score and reset; a slow
// instance (1000 ticks/s) leaves room for long answer sequences in one round.
module tb_switch_game_engine;

  typedef struct packed {
    logic [9:0] score;
    logic [7:0] mult;
    logic [9:0] led;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       fast_start, slow_start;
  logic [9:0] fast_sw, slow_sw;
  logic [9:0] fast_led, slow_led;
  logic [7:0] fast_sec, slow_sec;
  logic [9:0] fast_score, slow_score;
  logic [9:0] fast_high, slow_high;
  logic [7:0] fast_mult, slow_mult;
  logic       fast_playing, slow_playing;
  logic       fast_go, slow_go;
  logic       fast_nh, slow_nh;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   round_entry[2];
  int   m_idx[2];
  int   m_score[2];
  int   m_mult[2];
  int   m_streak[2];
  exp_t sb_q[$];

  switch_game_engine #(
    .NUM_SW(10), .TICKS_PER_SEC(4), .ROUND_SECONDS(3), .PROMPT_STEP(7),
    .STREAK_LEN(5), .MAX_MULT(8), .SCORE_W(10)
  ) dut_fast (
    .clk(clk), .reset(reset), .start(fast_start), .sw(fast_sw),
    .led_prompt(fast_led), .seconds_left(fast_sec), .score(fast_score),
    .high_score(fast_high), .multiplier(fast_mult), .playing(fast_playing),
    .game_over(fast_go), .new_high(fast_nh)
  );

  switch_game_engine #(
    .NUM_SW(10), .TICKS_PER_SEC(1000), .ROUND_SECONDS(3), .PROMPT_STEP(7),
    .STREAK_LEN(5), .MAX_MULT(8), .SCORE_W(10)
  ) dut_slow (
    .clk(clk), .reset(reset), .start(slow_start), .sw(slow_sw),
    .led_prompt(slow_led), .seconds_left(slow_sec), .score(slow_score),
    .high_score(slow_high), .multiplier(slow_mult), .playing(slow_playing),
    .game_over(slow_go), .new_high(slow_nh)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] oh(input int i);
    logic [9:0] one;
    one = 10'd1;
    return one << i;
  endfunction

  function automatic logic [31:0] get_score(input bit sel);
    return sel ? 32'(slow_score) : 32'(fast_score);
  endfunction
  function automatic logic [31:0] get_high(input bit sel);
    return sel ? 32'(slow_high) : 32'(fast_high);
  endfunction
  function automatic logic [31:0] get_mult(input bit sel);
    return sel ? 32'(slow_mult) : 32'(fast_mult);
  endfunction
  function automatic logic [31:0] get_led(input bit sel);
    return sel ? 32'(slow_led) : 32'(fast_led);
  endfunction
  function automatic logic [31:0] get_sec(input bit sel);
    return sel ? 32'(slow_sec) : 32'(fast_sec);
  endfunction
  function automatic logic [31:0] get_playing(input bit sel);
    return sel ? 32'(slow_playing) : 32'(fast_playing);
  endfunction
  function automatic logic [31:0] get_go(input bit sel);
    return sel ? 32'(slow_go) : 32'(fast_go);
  endfunction
  function automatic logic [31:0] get_nh(input bit sel);
    return sel ? 32'(slow_nh) : 32'(fast_nh);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Toggle switches and push the model's expectation for when the change lands
  task automatic applyStimulus(input bit sel, input logic [9:0] mask, input bit at_end);
    exp_t e;
    int   pts;
    if (sel) slow_sw = slow_sw ^ mask;
    else     fast_sw = fast_sw ^ mask;
    if (mask == oh(m_idx[sel])) begin
      pts = m_score[sel] + 2 * m_mult[sel];
      m_score[sel] = (pts > 1023) ? 1023 : pts;
      if (m_streak[sel] == 4) begin
        m_streak[sel] = 0;
        m_mult[sel]   = (m_mult[sel] * 2 > 8) ? 8 : m_mult[sel] * 2;
      end else begin
        m_streak[sel]++;
      end
    end else begin
      m_streak[sel] = 0;
      m_mult[sel]   = 1;
    end
    m_idx[sel] = (m_idx[sel] + 7) % 10;
    e.score = 10'(m_score[sel]);
    e.mult  = 8'(m_mult[sel]);
    e.led   = at_end ? 10'h3FF : oh(m_idx[sel]);
    sb_q.push_back(e);
  endtask

  task automatic scoreboardCheck(input bit sel, input string tag);
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checkOutput({tag, "_score"}, get_score(sel), 32'(e.score));
      checkOutput({tag, "_mult"},  get_mult(sel),  32'(e.mult));
      checkOutput({tag, "_led"},   get_led(sel),   32'(e.led));
    end
  endtask

  // One answer: the result must not show before the two-stage synchroniser latency
  task automatic toggle(input bit sel, input logic [9:0] mask, input string tag);
    int prev;
    prev = m_score[sel];
    applyStimulus(sel, mask, 1'b0);
    cycles(2);
    checkOutput({tag, "_early"}, get_score(sel), 32'(prev));
    cycles(1);
    scoreboardCheck(sel, tag);
  endtask

  task automatic startRound(input bit sel, input string tag);
    if (sel) slow_start = 1'b1; else fast_start = 1'b1;
    cycles(1);
    if (sel) slow_start = 1'b0; else fast_start = 1'b0;
    round_entry[sel] = cyc;
    m_score[sel]  = 0;
    m_mult[sel]   = 1;
    m_streak[sel] = 0;
    checkOutput({tag, "_playing"}, get_playing(sel), 32'd1);
    checkOutput({tag, "_score0"},  get_score(sel),   32'd0);
    checkOutput({tag, "_mult1"},   get_mult(sel),    32'd1);
    checkOutput({tag, "_sec"},     get_sec(sel),     32'd3);
    checkOutput({tag, "_led"},     get_led(sel),     32'(oh(m_idx[sel])));
  endtask

  task automatic waitGameOver(input bit sel, input int limit, input int round_len, input string tag);
    int n;
    n = 0;
    while (get_go(sel) != 32'd1 && n < limit) begin
      cycles(1);
      n++;
    end
    checkOutput({tag, "_game_over"}, get_go(sel), 32'd1);
    checkOutput({tag, "_round_len"}, 32'(cyc - round_entry[sel]), 32'(round_len));
    checkOutput({tag, "_sec0"},      get_sec(sel), 32'd0);
    checkOutput({tag, "_led_all"},   get_led(sel), 32'h3FF);
  endtask

  task automatic checkReset(input bit sel, input string tag);
    checkOutput({tag, "_led"},      get_led(sel),     32'd0);
    checkOutput({tag, "_sec"},      get_sec(sel),     32'd3);
    checkOutput({tag, "_score"},    get_score(sel),   32'd0);
    checkOutput({tag, "_high"},     get_high(sel),    32'd0);
    checkOutput({tag, "_mult"},     get_mult(sel),    32'd1);
    checkOutput({tag, "_playing"},  get_playing(sel), 32'd0);
    checkOutput({tag, "_game_over"},get_go(sel),      32'd0);
    checkOutput({tag, "_new_high"}, get_nh(sel),      32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    fast_start = 1'b0;
    slow_start = 1'b0;
    fast_sw    = '0;
    slow_sw    = '0;
    for (int i = 0; i < 2; i++) begin
      m_idx[i] = 0; m_score[i] = 0; m_mult[i] = 1; m_streak[i] = 0; round_entry[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkReset(1'b0, "rst_fast");
    checkReset(1'b1, "rst_slow");
    cycles(2);
    $display("[TB] start and idle expiry");

    startRound(1'b0, "exp");
    for (int k = 1; k <= 12; k++) begin
      cycles(1);
      checkOutput($sformatf("exp_sec_k%0d", k), get_sec(1'b0), 32'((k >= 12) ? 0 : 3 - k / 4));
      checkOutput($sformatf("exp_go_k%0d", k),  get_go(1'b0),  32'(k == 12));
    end
    checkOutput("exp_led_all", get_led(1'b0),   32'h3FF);
    checkOutput("exp_score",   get_score(1'b0), 32'd0);
    checkOutput("exp_new_high",get_nh(1'b0),    32'd0);
    cycles(2);
    checkOutput("exp_hold_go", get_go(1'b0),    32'd1);
    checkOutput("exp_hold_sec",get_sec(1'b0),   32'd0);
    checkOutput("exp_hold_nh", get_nh(1'b0),    32'd0);
    $display("[TB] high score rounds");

    startRound(1'b0, "hsA");
    toggle(1'b0, oh(m_idx[0]), "hsA_t1");
    toggle(1'b0, oh(m_idx[0]), "hsA_t2");
    toggle(1'b0, oh(m_idx[0]), "hsA_t3");
    waitGameOver(1'b0, 20, 12, "hsA");
    checkOutput("hsA_score",    get_score(1'b0), 32'd6);
    checkOutput("hsA_new_high", get_nh(1'b0),    32'd1);
    checkOutput("hsA_high",     get_high(1'b0),  32'd6);
    cycles(1);
    checkOutput("hsA_nh_once",  get_nh(1'b0),    32'd0);
    cycles(2);

    startRound(1'b0, "hsB");
    toggle(1'b0, oh(m_idx[0]), "hsB_t1");
    toggle(1'b0, oh(m_idx[0]), "hsB_t2");
    waitGameOver(1'b0, 20, 12, "hsB");
    checkOutput("hsB_score",    get_score(1'b0), 32'd4);
    checkOutput("hsB_new_high", get_nh(1'b0),    32'd0);
    checkOutput("hsB_high",     get_high(1'b0),  32'd6);
    cycles(1);
    checkOutput("hsB_nh_after", get_nh(1'b0),    32'd0);
    $display("[TB] correct toggles and streak");

    startRound(1'b1, "cor");
    for (int t = 0; t < 6; t++) begin
      toggle(1'b1, oh(m_idx[1]), $sformatf("cor_t%0d", t + 1));
      if (t == 4) checkOutput("cor_mult_after5", get_mult(1'b1), 32'd2);
    end
    checkOutput("cor_score14", get_score(1'b1), 32'd14);
    waitGameOver(1'b1, 4000, 3000, "cor");
    checkOutput("cor_new_high", get_nh(1'b1),   32'd1);
    checkOutput("cor_high",     get_high(1'b1), 32'd14);
    cycles(2);
    $display("[TB] wrong toggles");

    startRound(1'b1, "wr");
    toggle(1'b1, oh(m_idx[1]), "wr_c1");
    toggle(1'b1, oh(m_idx[1]), "wr_c2");
    toggle(1'b1, oh(m_idx[1]), "wr_c3");
    slow_start = 1'b1;
    cycles(1);
    slow_start = 1'b0;
    cycles(1);
    checkOutput("wr_start_ignored", get_score(1'b1),   32'd6);
    checkOutput("wr_still_playing", get_playing(1'b1), 32'd1);
    toggle(1'b1, oh((m_idx[1] + 1) % 10), "wr_other");
    checkOutput("wr_other_score", get_score(1'b1), 32'd6);
    checkOutput("wr_other_mult",  get_mult(1'b1),  32'd1);
    toggle(1'b1, oh(m_idx[1]) | oh((m_idx[1] + 5) % 10), "wr_double");
    checkOutput("wr_double_score", get_score(1'b1), 32'd6);
    for (int t = 0; t < 4; t++) begin
      toggle(1'b1, oh(m_idx[1]), $sformatf("wr_after%0d", t + 1));
    end
    checkOutput("wr_streak_reset_mult", get_mult(1'b1),  32'd1);
    checkOutput("wr_final_score",       get_score(1'b1), 32'd14);
    $display("[TB] reset mid-round and terminal-edge hit");

    startRound(1'b0, "rs");
    cycles(2);
    #3;
    reset = 1'b1;
    #1;
    checkReset(1'b0, "rs_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_idx[0] = 0;
    m_idx[1] = 0;
    cycles(3);
    checkReset(1'b0, "rs_idle");

    startRound(1'b0, "term");
    cycles(9);
    applyStimulus(1'b0, oh(m_idx[0]), 1'b1);
    cycles(3);
    scoreboardCheck(1'b0, "term_hit");
    checkOutput("term_game_over", get_go(1'b0),   32'd1);
    checkOutput("term_round_len", 32'(cyc - round_entry[0]), 32'd12);
    checkOutput("term_new_high",  get_nh(1'b0),   32'd1);
    checkOutput("term_high",      get_high(1'b0), 32'd2);
    cycles(1);
    checkOutput("term_nh_once",   get_nh(1'b0),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_game_engine.md
# switch_game_engine

Parametrised successor to the fixed 10-switch, 20-second reaction game core. It sits between the board switches/LEDs and the seven-segment formatting logic. It owns the round FSM, prompt generation, the countdown, streak-multiplied scoring and a persistent high score. All outputs are binary; BCD/hex conversion stays in the display layer.

## Interface
Parameters:
- NUM_SW, 10: number of switches/prompt LEDs (2..32)
- TICKS_PER_SEC, 50000000: clk cycles per countdown second
- ROUND_SECONDS, 20: round length in seconds (1..255)
- PROMPT_STEP, 7: prompt index increment; must be coprime with NUM_SW
- STREAK_LEN, 5: consecutive correct answers per multiplier doubling
- MAX_MULT, 8: multiplier cap (power of two)
- SCORE_W, 10: score and high-score width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears everything including high score
- start  in  1  level; sampled in IDLE/GAMEOVER to begin a round
- sw  in  NUM_SW  raw switch levels (asynchronous to clk)
- led_prompt  out  NUM_SW  one-hot prompt; all ones in GAMEOVER
- seconds_left  out  8  remaining seconds
- score  out  SCORE_W  current round score
- high_score  out  SCORE_W  best score since reset
- multiplier  out  8  current point multiplier (1..MAX_MULT)
- playing  out  1  high in PLAY
- game_over  out  1  high in GAMEOVER
- new_high  out  1  one-cycle pulse when high_score is updated

## Operation
- sw passes through a 2-flop synchroniser (sw_s); sw_prev registers sw_s; change = (sw_s != sw_prev).
- States are IDLE, PLAY, GAMEOVER.
- IDLE -> PLAY, and GAMEOVER -> PLAY, when start=1. Round init:
  - score=0, streak=0, multiplier=1, seconds_left=ROUND_SECONDS, tick=0
  - idx keeps its current value
  - expected = sw_s ^ onehot(idx)
- In PLAY, a change is evaluated on the same edge it is detected:
  - **Correct** (sw_s == expected): score += 2*multiplier, saturating at 2^SCORE_W-1. If streak==STREAK_LEN-1, then streak=0 and multiplier=min(2*multiplier, MAX_MULT); otherwise streak+=1. Points use the multiplier value before doubling.
  - **Wrong** (any other change, including several switches in one cycle): streak=0, multiplier=1, score unchanged.
  - After either outcome: idx=(idx+PROMPT_STEP) mod NUM_SW, and expected = sw_s ^ onehot(new idx).
- Countdown in PLAY:
  - tick counts 0..TICKS_PER_SEC-1.
  - At the wrap, seconds_left decrements.
  - Decrement 1->0 moves the FSM to GAMEOVER.
  - If score > high_score at that edge, high_score=score and new_high pulses.
- GAMEOVER holds score and seconds_left=0.
- led_prompt per state: IDLE=0, PLAY=onehot(idx), GAMEOVER=all ones.
- start while in PLAY is ignored.
- change events outside PLAY are tracked by sw_prev but never scored.

## Timing
- Reset values:
  - FSM=IDLE, idx=0, expected=0
  - score=0, high_score=0, multiplier=1, streak=0
  - seconds_left=ROUND_SECONDS
  - led_prompt=0, playing=0, game_over=0, new_high=0
  - sync flops, sw_prev and tick all 0
- Switch latency: an sw edge first sampled at clk edge k appears in score/led_prompt/multiplier after edge k+2.
- Round length: exactly ROUND_SECONDS*TICKS_PER_SEC cycles from the PLAY-entry edge to the GAMEOVER edge.
- A correct change on the terminal tick edge is scored, and the high-score comparison uses the updated score.
- new_high is asserted for exactly the cycle after the GAMEOVER-entry edge.
- Reset mid-round returns to IDLE immediately (asynchronous) and loses the high score.
- All arithmetic is unsigned. idx wraps mod NUM_SW, and the multiplier never exceeds MAX_MULT.

## Test plan
Parameters for all scenarios: NUM_SW=10, TICKS_PER_SEC=4, ROUND_SECONDS=3, STREAK_LEN=5, MAX_MULT=8, sw=0.
- **Start and idle expiry:** pulse start with sw=0, then no switch activity. Required:
  - led_prompt=0x001
  - seconds_left goes 3, 2, 1, 0 at 4-cycle intervals
  - game_over at cycle 12; led_prompt=0x3FF; score=0; no new_high
- **Correct toggles:** flip each prompted switch 6 times (needs TICKS_PER_SEC=1000). Required:
  - prompt indices 0, 7, 4, 1, 8, 5
  - score 2, 4, 6, 8, 10, then 14
  - multiplier=2 after the 5th correct
- **Wrong toggle:** after 3 correct answers, flip a non-prompted switch. Required: score stays 6, multiplier=1, prompt advances to the next index.
- **Two switches in one cycle:** flip the prompted switch plus one other switch together. Required: counted as wrong.
- **High score:** play round A scoring 6, then round B scoring 4. Required:
  - new_high pulses once after A; high_score=6 after both rounds
  - round B starts with score=0
- **Reset and terminal-edge hit:** assert reset mid-PLAY. Required: immediate IDLE, all outputs at reset values. Then land a correct toggle on the terminal tick edge. Required: it is scored, and the resulting score is captured into high_score.
